// File: rtl/sat_accum_if.sv
// -----------------------------------------------------------------------------
// sat_accum_if
//
// Bundles the sample/telemetry signals of sat_accum so the block can be wired
// as one port. The clock and reset stay outside as plain ports.
//
// Handshake: valid-only pulses, no backpressure. A *_vld bit qualifies its
// companion data for exactly the cycle in which it is high; there is no ready,
// so the consumer must take the data in that cycle. in_vld/in_val follow the
// same rule on the input side.
//
// Signals (master = sample producer / telemetry consumer, slave = sat_accum):
//   in_vld    master->slave  1      qualifies in_val for one cycle
//   in_val    master->slave  IN_W   raw sample
//   clr       master->slave  1      synchronous clear of accumulator/telemetry
//   sat_vld   slave->master  1      stage-1 valid pulse
//   sat_out   slave->master  OUT_W  registered clamped sample
//   acc_vld   slave->master  1      stage-2 valid pulse (acc updated)
//   acc       slave->master  OUT_W  saturating running sum
//   acc_clamp slave->master  1      with acc_vld: the sum was clamped
//   sat_hit   slave->master  1      sticky input-clamp flag
//   sat_cnt   slave->master  CNT_W  saturating count of input clamps
// -----------------------------------------------------------------------------
interface sat_accum_if #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 10,
  parameter int CNT_W = 8
) ();

  logic             in_vld;
  logic [IN_W-1:0]  in_val;
  logic             clr;
  logic             sat_vld;
  logic [OUT_W-1:0] sat_out;
  logic             acc_vld;
  logic [OUT_W-1:0] acc;
  logic             acc_clamp;
  logic             sat_hit;
  logic [CNT_W-1:0] sat_cnt;

  modport master (
    output in_vld,
    output in_val,
    output clr,
    input  sat_vld,
    input  sat_out,
    input  acc_vld,
    input  acc,
    input  acc_clamp,
    input  sat_hit,
    input  sat_cnt
  );

  modport slave (
    input  in_vld,
    input  in_val,
    input  clr,
    output sat_vld,
    output sat_out,
    output acc_vld,
    output acc,
    output acc_clamp,
    output sat_hit,
    output sat_cnt
  );

endinterface

// File: rtl/sat_accum.sv
// -----------------------------------------------------------------------------
// sat_accum
//
// Two-stage saturation / saturating-accumulation block for the control
// datapath. Stage 1 clamps a wide sample into the OUT_W range and registers
// it; stage 2 adds each clamped sample into a saturating accumulator (the PID
// integral term). Input clamp telemetry (sticky flag + saturating counter) is
// updated alongside stage 1.
//
// Parameters:
//   IN_W   input sample width
//   OUT_W  clamped sample / accumulator width (OUT_W < IN_W)
//   SIGNED 1: two's complement, range [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//          0: unsigned,        range [0, 2^OUT_W-1]
//   CNT_W  width of the clamp-event counter
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every output at once
//   bus    sat_accum_if.slave (in_vld/in_val/clr in; stage outputs and
//          telemetry out). See the interface for the valid-only handshake.
//
// Timing: in_vld at edge N -> sat_vld/sat_out/sat_hit/sat_cnt after N+1,
// acc_vld/acc/acc_clamp after N+2. One sample per cycle, no stalls.
// -----------------------------------------------------------------------------
module sat_accum #(
  parameter int IN_W   = 17,
  parameter int OUT_W  = 10,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 8
) (
  input logic         clk,
  input logic         rst_n,
  sat_accum_if.slave  bus
);

  localparam logic [OUT_W-1:0] MAX_V = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}}
                                                     : {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] MIN_V = (SIGNED != 0) ? {1'b1, {(OUT_W-1){1'b0}}}
                                                     : {OUT_W{1'b0}};

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic             sat_vld_q;
  logic [OUT_W-1:0] sat_out_q;
  logic             acc_vld_q;
  logic [OUT_W-1:0] acc_q;
  logic             acc_clamp_q;
  logic             sat_hit_q;
  logic [CNT_W-1:0] sat_cnt_q;

  // ---------------------------------------------------------------------------
  // Stage 1: range check and clamp of the raw sample
  // ---------------------------------------------------------------------------
  logic             in_over;
  logic             in_under;
  logic [OUT_W-1:0] in_clamped;

  always_comb begin
    in_over  = 1'b0;
    in_under = 1'b0;
    if (SIGNED != 0) begin
      // In range exactly when every bit from IN_W-2 down to OUT_W-1 copies
      // the sign bit; otherwise the sign tells which side overflowed.
      if (!bus.in_val[IN_W-1] && (|bus.in_val[IN_W-2:OUT_W-1])) begin
        in_over = 1'b1;
      end
      if (bus.in_val[IN_W-1] && !(&bus.in_val[IN_W-2:OUT_W-1])) begin
        in_under = 1'b1;
      end
    end else begin
      // Unsigned values cannot fall below 0, only above the top.
      in_over = |bus.in_val[IN_W-1:OUT_W];
    end

    if (in_over) begin
      in_clamped = MAX_V;
    end else if (in_under) begin
      in_clamped = MIN_V;
    end else begin
      in_clamped = bus.in_val[OUT_W-1:0];
    end
  end

  logic clamp_event;
  logic cnt_full;

  assign clamp_event = bus.in_vld && (in_over || in_under);
  assign cnt_full    = &sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_vld_q <= 1'b0;
      sat_out_q <= '0;
    end else begin
      sat_vld_q <= bus.in_vld;
      if (bus.in_vld) begin
        sat_out_q <= in_clamped;
      end
    end
  end

  // Telemetry: clr has priority over a coincident clamp event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_hit_q <= 1'b0;
      sat_cnt_q <= '0;
    end else if (bus.clr) begin
      sat_hit_q <= 1'b0;
      sat_cnt_q <= '0;
    end else if (clamp_event) begin
      sat_hit_q <= 1'b1;
      if (!cnt_full) begin
        sat_cnt_q <= sat_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: OUT_W+1 bit sum and clamp back into range
  // ---------------------------------------------------------------------------
  logic [OUT_W:0]   acc_ext;
  logic [OUT_W:0]   smp_ext;
  logic [OUT_W:0]   sum;
  logic             sum_over;
  logic             sum_under;
  logic [OUT_W-1:0] sum_clamped;

  always_comb begin
    if (SIGNED != 0) begin
      acc_ext = {acc_q[OUT_W-1], acc_q};
      smp_ext = {sat_out_q[OUT_W-1], sat_out_q};
    end else begin
      acc_ext = {1'b0, acc_q};
      smp_ext = {1'b0, sat_out_q};
    end
    sum = acc_ext + smp_ext;

    sum_over  = 1'b0;
    sum_under = 1'b0;
    if (SIGNED != 0) begin
      // The two top bits of the widened sum disagree only on overflow;
      // the top bit is the true sign and picks the side.
      sum_over  = !sum[OUT_W] &&  sum[OUT_W-1];
      sum_under =  sum[OUT_W] && !sum[OUT_W-1];
    end else begin
      sum_over  = sum[OUT_W];
    end

    if (sum_over) begin
      sum_clamped = MAX_V;
    end else if (sum_under) begin
      sum_clamped = MIN_V;
    end else begin
      sum_clamped = sum[OUT_W-1:0];
    end
  end

  // clr discards a coincident stage-1 sample from the sum and suppresses
  // its acc_vld pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      acc_clamp_q <= 1'b0;
    end else if (bus.clr) begin
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      acc_clamp_q <= 1'b0;
    end else if (sat_vld_q) begin
      acc_q       <= sum_clamped;
      acc_vld_q   <= 1'b1;
      acc_clamp_q <= sum_over || sum_under;
    end else begin
      acc_vld_q   <= 1'b0;
      acc_clamp_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.sat_vld   = sat_vld_q;
  assign bus.sat_out   = sat_out_q;
  assign bus.acc_vld   = acc_vld_q;
  assign bus.acc       = acc_q;
  assign bus.acc_clamp = acc_clamp_q;
  assign bus.sat_hit   = sat_hit_q;
  assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sat_accum.sv
// -----------------------------------------------------------------------------
// tb_sat_accum
//
// Two instances share clk/rst_n:
//   dut_s : SIGNED=1, IN_W=17, OUT_W=10, CNT_W=4  (range -512..511, cnt max 15)
//   dut_u : SIGNED=0, IN_W=17, OUT_W=10, CNT_W=8  (range 0..1023,   cnt max 255)
// Inputs change on the falling edge; outputs are compared on the next falling
// edge against a reference model that tracks the block's observable behaviour
// with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sat_accum;

  localparam int IN_W  = 17;
  localparam int OUT_W = 10;

  logic clk;
  logic rst_n;

  sat_accum_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(4)) if_s ();
  sat_accum_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(8)) if_u ();

  sat_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(1), .CNT_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s.slave)
  );

  sat_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(0), .CNT_W(8)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_u.slave)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (index 0 = signed instance, 1 = unsigned instance)
  // ---------------------------------------------------------------------------
  longint lo_lim [2];
  longint hi_lim [2];
  longint cnt_max[2];

  bit     m_svld [2];
  longint m_out  [2];
  bit     m_avld [2];
  longint m_acc  [2];
  bit     m_aclp [2];
  bit     m_hit  [2];
  longint m_cnt  [2];

  // Stimulus for the next cycle.
  bit     d_vld [2];
  longint d_val [2];
  bit     d_clr [2];

  function automatic longint clampv(input int i, input longint x);
    if (x > hi_lim[i]) return hi_lim[i];
    if (x < lo_lim[i]) return lo_lim[i];
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_svld[i] = 0; m_out[i] = 0; m_avld[i] = 0; m_acc[i] = 0;
      m_aclp[i] = 0; m_hit[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // One clock edge worth of behaviour, using the values visible before it.
  task automatic model_step(input int i);
    longint sum;
    longint cl;
    if (d_clr[i]) begin
      m_acc[i] = 0; m_avld[i] = 0; m_aclp[i] = 0;
    end else if (m_svld[i]) begin
      sum = m_acc[i] + m_out[i];
      cl  = clampv(i, sum);
      m_acc[i]  = cl;
      m_avld[i] = 1;
      m_aclp[i] = (cl != sum);
    end else begin
      m_avld[i] = 0; m_aclp[i] = 0;
    end

    if (d_clr[i]) begin
      m_hit[i] = 0; m_cnt[i] = 0;
    end else if (d_vld[i] && clampv(i, d_val[i]) != d_val[i]) begin
      m_hit[i] = 1;
      if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
    end

    m_svld[i] = d_vld[i];
    if (d_vld[i]) m_out[i] = clampv(i, d_val[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Checks of all outputs against the model
  // ---------------------------------------------------------------------------
  task automatic check_s(input string tag);
    logic signed [63:0] v;
    chk({tag, " s.sat_vld"}, if_s.sat_vld, m_svld[0]);
    v = $signed(if_s.sat_out);
    chk({tag, " s.sat_out"}, v, m_out[0]);
    chk({tag, " s.acc_vld"}, if_s.acc_vld, m_avld[0]);
    v = $signed(if_s.acc);
    chk({tag, " s.acc"}, v, m_acc[0]);
    chk({tag, " s.acc_clamp"}, if_s.acc_clamp, m_aclp[0]);
    chk({tag, " s.sat_hit"}, if_s.sat_hit, m_hit[0]);
    chk({tag, " s.sat_cnt"}, if_s.sat_cnt, m_cnt[0]);
  endtask

  task automatic check_u(input string tag);
    chk({tag, " u.sat_vld"}, if_u.sat_vld, m_svld[1]);
    chk({tag, " u.sat_out"}, if_u.sat_out, m_out[1]);
    chk({tag, " u.acc_vld"}, if_u.acc_vld, m_avld[1]);
    chk({tag, " u.acc"}, if_u.acc, m_acc[1]);
    chk({tag, " u.acc_clamp"}, if_u.acc_clamp, m_aclp[1]);
    chk({tag, " u.sat_hit"}, if_u.sat_hit, m_hit[1]);
    chk({tag, " u.sat_cnt"}, if_u.sat_cnt, m_cnt[1]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one cycle. Called at a falling edge, returns at the next one.
  // ---------------------------------------------------------------------------
  task automatic tick(input string tag);
    logic [63:0] raw;
    raw = d_val[0];
    if_s.in_vld = d_vld[0];
    if_s.in_val = raw[IN_W-1:0];
    if_s.clr    = d_clr[0];
    raw = d_val[1];
    if_u.in_vld = d_vld[1];
    if_u.in_val = raw[IN_W-1:0];
    if_u.clr    = d_clr[1];
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_s(tag);
    check_u(tag);
    for (int i = 0; i < 2; i++) begin
      d_vld[i] = 0; d_val[i] = 0; d_clr[i] = 0;
    end
  endtask

  task automatic put(input int i, input longint val);
    d_vld[i] = 1;
    d_val[i] = val;
  endtask

  // Asynchronous reset between edges; outputs must drop immediately.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_s(tag);
    check_u(tag);
    @(negedge clk);
    check_s({tag, "_held"});
    check_u({tag, "_held"});
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    logic signed [63:0] v;
    lo_lim[0] = -512; hi_lim[0] = 511;  cnt_max[0] = 15;
    lo_lim[1] = 0;    hi_lim[1] = 1023; cnt_max[1] = 255;
    for (int i = 0; i < 2; i++) begin
      d_vld[i] = 0; d_val[i] = 0; d_clr[i] = 0;
    end
    model_reset();
    if_s.in_vld = 0; if_s.in_val = '0; if_s.clr = 0;
    if_u.in_vld = 0; if_u.in_val = '0; if_u.clr = 0;

    // Reset state, during and after reset.
    rst_n = 1'b0;
    #2;
    check_s("rst");
    check_u("rst");
    @(negedge clk);
    @(negedge clk);
    check_s("rst_hold");
    check_u("rst_hold");
    rst_n = 1'b1;
    tick("post_rst");

    // Boundary samples on the signed instance.
    put(0, 511);  tick("b511");  tick("b511_idle");
    v = $signed(if_s.sat_out); chk("t1 sat_out 511", v, 511);
    chk("t1 hit clear", if_s.sat_hit, 0);
    put(0, 512);  tick("b512");
    v = $signed(if_s.sat_out); chk("t1 sat_out 512", v, 511);
    chk("t1 hit set", if_s.sat_hit, 1);
    tick("b512_idle");
    put(0, -512); tick("bm512"); tick("bm512_idle");
    v = $signed(if_s.sat_out); chk("t1 sat_out -512", v, -512);
    put(0, -600); tick("bm600"); tick("bm600_idle");
    v = $signed(if_s.sat_out); chk("t1 sat_out -600", v, -512);
    put(0, 0);    tick("b0");    tick("b0_idle");
    v = $signed(if_s.sat_out); chk("t1 sat_out 0", v, 0);
    chk("t1 sat_cnt", if_s.sat_cnt, 2);

    // Pipeline latency, then back-to-back into positive saturation.
    d_clr[0] = 1; tick("t2_clr");
    put(0, 100); tick("t2_in");
    chk("t2 sat_vld", if_s.sat_vld, 1);
    chk("t2 acc_vld early", if_s.acc_vld, 0);
    tick("t2_s2");
    chk("t2 acc_vld", if_s.acc_vld, 1);
    v = $signed(if_s.acc); chk("t2 acc", v, 100);
    tick("t2_gap");
    for (int k = 0; k < 6; k++) begin
      put(0, 100);
      tick("t2_b2b");
      if (k >= 1) chk("t2 b2b acc_vld", if_s.acc_vld, 1);
    end
    tick("t2_drain");
    chk("t2 last acc_vld", if_s.acc_vld, 1);
    v = $signed(if_s.acc); chk("t2 final acc", v, 511);
    chk("t2 last clamp", if_s.acc_clamp, 1);
    tick("t2_idle");
    chk("t2 pulse ends", if_s.acc_vld, 0);

    // Negative accumulator clamp.
    d_clr[0] = 1; tick("t3_clr");
    put(0, -500); tick("t3_a"); tick("t3_a2");
    v = $signed(if_s.acc); chk("t3 acc -500", v, -500);
    put(0, -100); tick("t3_b"); tick("t3_b2");
    v = $signed(if_s.acc); chk("t3 acc -512", v, -512);
    chk("t3 clamp", if_s.acc_clamp, 1);
    put(0, 50); tick("t3_c"); tick("t3_c2");
    v = $signed(if_s.acc); chk("t3 acc -462", v, -462);
    chk("t3 no clamp", if_s.acc_clamp, 0);

    // Unsigned instance: large input, accumulator pinned at the top.
    put(1, 65535); tick("t4_a");
    chk("t4 sat_out", if_u.sat_out, 1023);
    for (int k = 0; k < 4; k++) begin
      put(1, 65535);
      tick("t4_b2b");
    end
    tick("t4_drain");
    chk("t4 acc", if_u.acc, 1023);
    chk("t4 clamp", if_u.acc_clamp, 1);

    // clr collides with a stage-1 sample carrying 200.
    put(0, 900); tick("t5_hit");
    put(0, 200); tick("t5_in");
    d_clr[0] = 1; tick("t5_clr");
    chk("t5 acc", if_s.acc, 0);
    chk("t5 acc_vld", if_s.acc_vld, 0);
    chk("t5 hit", if_s.sat_hit, 0);
    chk("t5 cnt", if_s.sat_cnt, 0);
    v = $signed(if_s.sat_out); chk("t5 sat_out", v, 200);
    // clr collides with an input clamp event.
    put(0, 9999); d_clr[0] = 1; tick("t5_clr_evt");
    chk("t5b hit", if_s.sat_hit, 0);
    chk("t5b cnt", if_s.sat_cnt, 0);
    tick("t5_idle");

    // Counter saturation on the 4-bit counter, then reset mid-stream.
    for (int k = 0; k < 20; k++) begin
      put(0, (k % 2 == 0) ? 40000 : -40000);
      tick("t6_oor");
    end
    chk("t6 cnt", if_s.sat_cnt, 15);
    chk("t6 hit", if_s.sat_hit, 1);
    put(0, 7); put(1, 7); tick("t6_inflight");
    pulse_reset("t6_rst");
    for (int k = 0; k < 3; k++) begin
      tick("t6_after");
      chk("t6 no acc_vld", if_s.acc_vld, 0);
    end

    // Randomized traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        d_vld[i] = ($urandom_range(0, 3) != 0);
        d_clr[i] = ($urandom_range(0, 24) == 0);
        case ($urandom_range(0, 3))
          0: d_val[i] = longint'($urandom_range(0, 131071));
          1: d_val[i] = hi_lim[i] - 2 + longint'($urandom_range(0, 4));
          2: d_val[i] = lo_lim[i] - 2 + longint'($urandom_range(0, 4));
          default: d_val[i] = longint'($urandom_range(0, 400)) - 200;
        endcase
        // Signed inputs span -65536..65535, unsigned 0..131071.
        if (i == 0 && d_val[i] > 65535) d_val[i] = d_val[i] - 131072;
        if (i == 1 && d_val[i] < 0) d_val[i] = d_val[i] + 131072;
      end
      tick("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
